// File: rtl/frame_pkg.sv
// Shared frame-buffer definitions: reader FSM states and default stored/full geometry.
// Used by frame_reader (optional FRAME_READER_REPEAT_EN upscale) and the downscaler.
package frame_pkg;

   typedef enum logic [2:0] {
      IDLE,
      VSYNC,
      HSYNC,
      ACTIVE,
      HBLANK,
      DONE
   } state_t;

   localparam int H_OUT_DEF     = 384;
   localparam int V_OUT_DEF     = 256;
   localparam int H_BLANK_DEF   = 16;
   localparam int AW_DEF        = 19;
   localparam int BASE_ADDR_DEF = 1;

   // pre-decimation geometry; FRAME_READER_REPEAT_EN output matches it
   localparam int H_FULL = 768;
   localparam int V_FULL = 512;

endpackage

// File: rtl/frame_reader_addr.sv
// Read-address generator for frame_reader: ra = line base + offset within the line.
// With FRAME_READER_REPEAT_EN each pixel is read twice and each line replayed once.
module frame_reader_addr
   import frame_pkg::*;
#(
   parameter int H_OUT     = H_OUT_DEF,
   parameter int AW        = AW_DEF,
   parameter int BASE_ADDR = BASE_ADDR_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          frame_start,
   input  logic          load,
   input  logic          line_end,
   output logic [AW-1:0] ra
);

   localparam int OW = $clog2(H_OUT + 1);

   logic [AW-1:0] line_base;
   logic [OW-1:0] offset;

`ifdef FRAME_READER_REPEAT_EN
   logic phase;   // second read of the current pixel pending
   logic copy;    // second copy of the current line in progress

   always_ff @(posedge clk) begin
      if (rst || frame_start) begin
         line_base <= AW'(BASE_ADDR);
         offset    <= '0;
         phase     <= 1'b0;
         copy      <= 1'b0;
      end else if (line_end) begin
         // clearing offset rewinds to the line base after the first copy
         offset <= '0;
         phase  <= 1'b0;
         copy   <= !copy;
         if (copy)
            line_base <= line_base + AW'(H_OUT);
      end else if (load) begin
         phase <= !phase;
         if (phase)
            offset <= offset + 1'b1;
      end
   end
`else
   always_ff @(posedge clk) begin
      if (rst || frame_start) begin
         line_base <= AW'(BASE_ADDR);
         offset    <= '0;
      end else if (line_end) begin
         line_base <= line_base + AW'(H_OUT);
         offset    <= '0;
      end else if (load) begin
         offset <= offset + 1'b1;
      end
   end
`endif

   assign ra = line_base + AW'(offset);

endmodule

// File: rtl/frame_reader.sv
// Streams a stored frame out of the frame RAM with regenerated V_sig/H_sig/enable framing.
// Define FRAME_READER_REPEAT_EN for 2x nearest-neighbour upscaled readout.
module frame_reader
   import frame_pkg::*;
#(
   parameter int H_OUT     = H_OUT_DEF,
   parameter int V_OUT     = V_OUT_DEF,
   parameter int H_BLANK   = H_BLANK_DEF,
   parameter int AW        = AW_DEF,
   parameter int BASE_ADDR = BASE_ADDR_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic [AW-1:0] ra,
   input  logic [7:0]    ram_out,
   output logic [7:0]    dout,
   output logic          enable,
   input  logic          ready,
   output logic          H_sig,
   output logic          V_sig,
   output logic          busy,
   output logic          done
);

`ifdef FRAME_READER_REPEAT_EN
   localparam int REP = 2;
`else
   localparam int REP = 1;
`endif

   localparam int PW = $clog2(2 * H_OUT + 1);
   localparam int LW = $clog2(2 * V_OUT + 1);
   localparam int BW = $clog2(H_BLANK + 1);

   localparam logic [PW-1:0] N_PIX  = PW'(REP * H_OUT);
   localparam logic [LW-1:0] N_LINE = LW'(REP * V_OUT);

   state_t state, state_nx;

   logic [PW-1:0] pix_cnt;
   logic [LW-1:0] line_cnt;
   logic [BW-1:0] blank_cnt;
   logic          accept, load, last_pix, last_blank;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path infers a latch.
      state_nx   = state;
      accept     = (state == ACTIVE) && enable && ready;
      last_pix   = accept && (pix_cnt == N_PIX - 1'b1);
      last_blank = (state == HBLANK) && (blank_cnt == BW'(H_BLANK - 1));
      // HSYNC prefetches the first pixel so enable rises as ACTIVE begins
      load       = (state == HSYNC) ||
                   ((state == ACTIVE) && (!enable || ready) &&
                    ((pix_cnt + PW'(enable)) < N_PIX));

      case (state)
         IDLE:    if (start) state_nx = VSYNC;
         VSYNC:   state_nx = HSYNC;
         HSYNC:   state_nx = ACTIVE;
         ACTIVE:  if (last_pix) state_nx = HBLANK;
         HBLANK:  if (last_blank)
                     state_nx = (line_cnt + 1'b1 == N_LINE) ? DONE : HSYNC;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: registered state is always assigned non-blocking.
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pix_cnt   <= '0;
         line_cnt  <= '0;
         blank_cnt <= '0;
         dout      <= '0;
         enable    <= 1'b0;
      end else begin
         if (state == VSYNC)   line_cnt <= '0;
         else if (last_blank)  line_cnt <= line_cnt + 1'b1;

         if (state == HSYNC)   pix_cnt <= '0;
         else if (accept)      pix_cnt <= pix_cnt + 1'b1;

         if (state == HBLANK)  blank_cnt <= blank_cnt + 1'b1;
         else                  blank_cnt <= '0;

         if (load) begin
            dout   <= ram_out;
            enable <= 1'b1;
         end else if (accept) begin
            enable <= 1'b0;
         end
      end
   end

   assign V_sig = (state == VSYNC);
   assign H_sig = (state == HSYNC);
   assign busy  = (state != IDLE);
   assign done  = (state == DONE);

   // held through DONE and IDLE so ra rests at BASE_ADDR between frames
   frame_reader_addr #(
      .H_OUT     (H_OUT),
      .AW        (AW),
      .BASE_ADDR (BASE_ADDR)
   ) u_addr (
      .clk         (clk),
      .rst         (rst),
      .frame_start ((state == IDLE) || (state == DONE)),
      .load        (load),
      .line_end    (last_blank),
      .ra          (ra)
   );

endmodule

// File: tb/tb_frame_reader.sv
// Self-checking bench for frame_reader: stored-frame model plus hand-computed timing/pixel literals.
// Build with FRAME_READER_REPEAT_EN to check the 2x upscale readout.
module tb_frame_reader;
   import frame_pkg::*;

`ifdef FRAME_READER_REPEAT_EN
   localparam int H = 2, V = 2, HB = 2, REP = 2;
   localparam int NP = 16, NH = 4, DONE_REL = 30;
   localparam int H_REL [NH] = '{2, 9, 16, 23};
   localparam logic [7:0] LIT [NP] = '{8'd1, 8'd1, 8'd2, 8'd2, 8'd1, 8'd1, 8'd2, 8'd2,
                                       8'd3, 8'd3, 8'd4, 8'd4, 8'd3, 8'd3, 8'd4, 8'd4};
`else
   localparam int H = 4, V = 2, HB = 2, REP = 1;
   localparam int NP = 8, NH = 2, DONE_REL = 16;
   localparam int H_REL [NH] = '{2, 9};
   localparam logic [7:0] LIT [NP] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
`endif
   localparam int AW = 19, BASE = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          ready = 1'b1;
   logic [AW-1:0] ra;
   logic [7:0]    ram_out, dout;
   logic          enable, H_sig, V_sig, busy, done;

   frame_reader #(
      .H_OUT (H), .V_OUT (V), .H_BLANK (HB), .AW (AW), .BASE_ADDR (BASE)
   ) dut (
      .clk (clk), .rst (rst), .start (start), .ra (ra), .ram_out (ram_out),
      .dout (dout), .enable (enable), .ready (ready), .H_sig (H_sig),
      .V_sig (V_sig), .busy (busy), .done (done)
   );

   // ram_reg preloaded with mem[a] = a[7:0], combinational read
   assign ram_out = ra[7:0];

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_pass = 0;
   int t0 = 0, first_en = -1;
   int v_q[$], h_q[$], d_q[$];
   logic [7:0] acc_q[$], exp_q[$];
   int rmode = 0;
   logic [3:0] rpat = 4'b1001;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic clear_rec();
      v_q.delete(); h_q.delete(); d_q.delete();
      acc_q.delete(); exp_q.delete();
      first_en = -1;
   endtask

   // stored frame replayed REP x REP: output line l, beat p reads stored (l/REP, p/REP)
   task automatic build_model();
      for (int l = 0; l < REP * V; l++)
         for (int p = 0; p < REP * H; p++)
            exp_q.push_back(8'(BASE + (l / REP) * H + p / REP));
   endtask

   task automatic start_frame();
      clear_rec();
      build_model();
      @(posedge clk); #1;
      start = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 4000) begin
         @(negedge clk);
         n++;
      end
      check("done_seen", 32'(done), 1);
      @(negedge clk);
   endtask

   task automatic check_frame();
      check("done_count", d_q.size(), 1);
      check("h_count", h_q.size(), NH);
      check("pix_count", acc_q.size(), NP);
      for (int i = 0; i < NP && i < acc_q.size(); i++)
         check($sformatf("pix_lit[%0d]", i), 32'(acc_q[i]), 32'(LIT[i]));
      check("idle_busy", 32'(busy), 0);
      check("idle_ra", 32'(ra), BASE);
   endtask

   initial forever begin
      @(posedge clk); #1;
      ready = (rmode == 0) ? 1'b1 : rpat[cyc % 4];
   end

   // compare process: model vs DUT on every accepted beat, plus stall and framing rules
   initial begin : monitor
      logic       prev_stall;
      logic [7:0] prev_dout;
      logic [AW-1:0] prev_ra;
      prev_stall = 1'b0;
      prev_dout  = '0;
      prev_ra    = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               check("stall_enable", 32'(enable), 1);
               check("stall_dout", 32'(dout), 32'(prev_dout));
               check("stall_ra", 32'(ra), 32'(prev_ra));
            end
            if (busy)
               check("sync_excl", 32'({V_sig && H_sig, (V_sig || H_sig) && enable}), 0);
            if (V_sig) v_q.push_back(cyc - t0);
            if (H_sig) h_q.push_back(cyc - t0);
            if (done) begin
               d_q.push_back(cyc - t0);
               check("done_all_pix", exp_q.size(), 0);
            end
            if (enable && first_en < 0) first_en = cyc - t0;
            if (enable && ready) begin
               acc_q.push_back(dout);
               if (exp_q.size() == 0) check("pix_overrun", exp_q.size(), 1);
               else check("pix_model", 32'(dout), 32'(exp_q.pop_front()));
            end
            prev_stall = enable && !ready;
            prev_dout  = dout;
            prev_ra    = ra;
         end
      end
   end

   initial begin
      int n;
      // reset and idle
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(negedge clk);
      check("rst_dout", 32'(dout), 0);
      check("rst_enable", 32'(enable), 0);
      check("rst_vh", 32'({V_sig, H_sig}), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_ra", 32'(ra), BASE);

      // rst and start together: reset wins
      @(posedge clk); #1;
      rst = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("rst_wins_busy", 32'(busy), 0);
      check("rst_wins_vsig", 32'(V_sig), 0);
      repeat (3) @(negedge clk);
      check("rst_wins_idle", 32'(busy), 0);

      // frame with ready held high: timing pinned by literals
      start_frame();
      wait_done();
      check("v_count", v_q.size(), 1);
      check("v_rel", (v_q.size() > 0) ? v_q[0] : -1, 1);
      for (int i = 0; i < NH && i < h_q.size(); i++)
         check($sformatf("h_rel[%0d]", i), h_q[i], H_REL[i]);
      check("first_en_rel", first_en, 3);
      check("done_rel", (d_q.size() > 0) ? d_q[0] : -1, DONE_REL);
      check_frame();

      // ready toggling 1,0,0,1
      rmode = 1;
      start_frame();
      wait_done();
      check_frame();
      rmode = 0;

      // reset on the third pixel of line 0, then restart
      start_frame();
      n = 0;
      while ((cyc - t0) != 5 && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("third_pix", 32'(dout), 32'(LIT[2]));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("midrst_enable", 32'(enable), 0);
      check("midrst_busy", 32'(busy), 0);
      check("midrst_dout", 32'(dout), 0);
      check("midrst_ra", 32'(ra), BASE);
      check("midrst_done", 32'(done), 0);
      clear_rec();
      repeat (5) @(negedge clk);
      check("midrst_no_done", d_q.size(), 0);
      start_frame();
      wait_done();
      check_frame();

      // start pulses inside the frame are ignored
      start_frame();
      n = 0;
      while (!enable && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (3) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done();
      check_frame();
      repeat (10) @(negedge clk);
      check("no_second_frame_done", d_q.size(), 1);
      check("no_second_frame_busy", 32'(busy), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
